// File: rtl/snake_write_sequencer.sv
// snake_write_sequencer
// Sole owner of the game-state register file write port. It grants processor
// stores in IDLE and, on each game tick, runs an atomic burst that shifts the
// body-position slots up by one, top slot first, then writes the new head.
module snake_write_sequencer #(
  parameter int NUM_SLOTS = 20,
  parameter int SLOT_BASE = 110,
  parameter int SLOT_W    = 11,
  parameter int SLOT_LSB  = 520,
  parameter int STATE_W   = 740
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic [31:0]        cpu_index,
  input  logic [31:0]        cpu_value,
  output logic               cpu_ack,
  input  logic               tick,
  input  logic [SLOT_W-1:0]  new_head,
  input  logic [STATE_W-1:0] snake_state,
  output logic               reg_enable,
  output logic [31:0]        reg_index,
  output logic [31:0]        reg_value,
  output logic               busy,
  output logic               tick_overrun
);

  localparam int K_W = (NUM_SLOTS > 2) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HEAD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [SLOT_W-1:0]   head_q, head_d;
  logic                reg_enable_q, reg_enable_d;
  logic [31:0]         reg_index_q, reg_index_d;
  logic [31:0]         reg_value_q, reg_value_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                tick_overrun_q, tick_overrun_d;

  // Extract body slot j from the read bus (shift keeps the select width-clean).
  function automatic logic [SLOT_W-1:0] slot_at(input int j);
    slot_at = SLOT_W'(snake_state >> (SLOT_LSB + SLOT_W * j));
  endfunction

  // State register; reset aborts any burst in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: a tick starts the burst, k==1 moves to the head write.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tick) state_d = SHIFT;
      SHIFT:   if (k_q <= K_W'(1)) state_d = HEAD;
      HEAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write-port and bookkeeping next values for each state.
  always_comb begin
    k_d            = k_q;
    head_d         = head_q;
    reg_enable_d   = 1'b0;
    reg_index_d    = reg_index_q;
    reg_value_d    = reg_value_q;
    cpu_ack_d      = 1'b0;
    tick_overrun_d = tick_overrun_q | (tick & (state_q != IDLE));
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          // Tick outranks the CPU; the CPU request simply stays pending.
          head_d       = new_head;
          k_d          = K_W'(NUM_SLOTS - 1);
          reg_enable_d = 1'b1;
          reg_index_d  = SLOT_BASE + NUM_SLOTS - 1;
          reg_value_d  = 32'(slot_at(NUM_SLOTS - 2));
        end else if (cpu_req && !cpu_ack_q) begin
          // The ack cycle masks the still-held request, so grants are >= 2 apart.
          reg_enable_d = 1'b1;
          reg_index_d  = cpu_index;
          reg_value_d  = cpu_value;
          cpu_ack_d    = 1'b1;
        end
      end
      SHIFT: begin
        reg_enable_d = 1'b1;
        if (k_q > K_W'(1)) begin
          // Top-down: slot[k-2] is read before anything below it is rewritten.
          k_d         = k_q - K_W'(1);
          reg_index_d = SLOT_BASE + int'(k_q) - 1;
          reg_value_d = 32'(slot_at(int'(k_q) - 2));
        end else begin
          k_d         = '0;
          reg_index_d = SLOT_BASE;
          reg_value_d = 32'(head_q);
        end
      end
      HEAD: begin
        // The port frees up on this edge, so a waiting CPU store goes out now.
        if (cpu_req && !cpu_ack_q) begin
          reg_enable_d = 1'b1;
          reg_index_d  = cpu_index;
          reg_value_d  = cpu_value;
          cpu_ack_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered write port, slot counter, latched head and sticky overrun.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      k_q            <= '0;
      head_q         <= '0;
      reg_enable_q   <= 1'b0;
      reg_index_q    <= '0;
      reg_value_q    <= '0;
      cpu_ack_q      <= 1'b0;
      tick_overrun_q <= 1'b0;
    end else begin
      k_q            <= k_d;
      head_q         <= head_d;
      reg_enable_q   <= reg_enable_d;
      reg_index_q    <= reg_index_d;
      reg_value_q    <= reg_value_d;
      cpu_ack_q      <= cpu_ack_d;
      tick_overrun_q <= tick_overrun_d;
    end
  end

  assign cpu_ack      = cpu_ack_q;
  assign reg_enable   = reg_enable_q;
  assign reg_index    = reg_index_q;
  assign reg_value    = reg_value_q;
  assign tick_overrun = tick_overrun_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_snake_write_sequencer.sv
// Directed bench for snake_write_sequencer: CPU store vectors from a table,
// hand-written sequences for tick bursts, overrun and mid-burst reset.
module tb_snake_write_sequencer;

  localparam int NS = 20;
  localparam int SB = 110;

  logic         clock = 1'b0;
  logic         reset;
  logic         cpu_req;
  logic [31:0]  cpu_index;
  logic [31:0]  cpu_value;
  logic         cpu_ack;
  logic         tick;
  logic [10:0]  new_head;
  logic [739:0] snake_state;
  logic         reg_enable;
  logic [31:0]  reg_index;
  logic [31:0]  reg_value;
  logic         busy;
  logic         tick_overrun;

  int tests = 0;
  int fails = 0;

  snake_write_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_index    (cpu_index),
    .cpu_value    (cpu_value),
    .cpu_ack      (cpu_ack),
    .tick         (tick),
    .new_head     (new_head),
    .snake_state  (snake_state),
    .reg_enable   (reg_enable),
    .reg_index    (reg_index),
    .reg_value    (reg_value),
    .busy         (busy),
    .tick_overrun (tick_overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        req;
    logic [31:0] idx;
    logic [31:0] val;
    logic        e_en;
    logic        e_ack;
    logic [31:0] e_idx;
    logic [31:0] e_val;
  } cpu_vec_t;

  cpu_vec_t vec [9];

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1 ({tag, " reg_enable"}, reg_enable, 1'b0);
    chk32({tag, " reg_index"}, reg_index, 32'd0);
    chk32({tag, " reg_value"}, reg_value, 32'd0);
    chk1 ({tag, " cpu_ack"}, cpu_ack, 1'b0);
    chk1 ({tag, " busy"}, busy, 1'b0);
    chk1 ({tag, " tick_overrun"}, tick_overrun, 1'b0);
  endtask

  // Full tick burst: expected order is 129..111 carrying slot[k-1] = 3*(k-1),
  // then index 110 carrying the head sampled with the tick. tick2_at >= 0
  // pulses a second tick so that it is sampled at burst cycle tick2_at.
  task automatic burst(input string tag, input logic [10:0] head, input int tick2_at);
    int exp_idx;
    int exp_val;
    tick     = 1'b1;
    new_head = head;
    for (int i = 0; i < NS; i++) begin
      step();
      tick     = ((i + 1) == tick2_at);
      new_head = ~head;
      exp_idx  = (i < NS - 1) ? (SB + NS - 1 - i) : SB;
      exp_val  = (i < NS - 1) ? (3 * (NS - 2 - i)) : int'(head);
      chk1 ($sformatf("%s c%0d reg_enable", tag, i), reg_enable, 1'b1);
      chk32($sformatf("%s c%0d reg_index", tag, i), reg_index, 32'(exp_idx));
      chk32($sformatf("%s c%0d reg_value", tag, i), reg_value, 32'(exp_val));
      chk1 ($sformatf("%s c%0d busy", tag, i), busy, 1'b1);
      chk1 ($sformatf("%s c%0d cpu_ack", tag, i), cpu_ack, 1'b0);
    end
    tick = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_index = '0;
    cpu_value = '0;
    tick      = 1'b0;
    new_head  = '0;
    // Non-slot bits set to ones so a wrong slice or missing zero-extension shows.
    snake_state = '1;
    for (int k = 0; k < NS; k++) snake_state[520 + 11 * k +: 11] = 11'(3 * k);

    vec[0] = '{1'b1, 32'd104, 32'hDEADBEEF, 1'b1, 1'b1, 32'd104, 32'hDEADBEEF};
    vec[1] = '{1'b1, 32'd104, 32'hDEADBEEF, 1'b0, 1'b0, 32'd104, 32'hDEADBEEF};
    vec[2] = '{1'b1, 32'd104, 32'hDEADBEEF, 1'b1, 1'b1, 32'd104, 32'hDEADBEEF};
    vec[3] = '{1'b1, 32'd104, 32'hDEADBEEF, 1'b0, 1'b0, 32'd104, 32'hDEADBEEF};
    vec[4] = '{1'b0, 32'd104, 32'hDEADBEEF, 1'b0, 1'b0, 32'd104, 32'hDEADBEEF};
    vec[5] = '{1'b1, 32'd7,   32'h12345678, 1'b1, 1'b1, 32'd7,   32'h12345678};
    vec[6] = '{1'b0, 32'd9,   32'h0BADF00D, 1'b0, 1'b0, 32'd7,   32'h12345678};
    vec[7] = '{1'b1, 32'd0,   32'h00000000, 1'b1, 1'b1, 32'd0,   32'h00000000};
    vec[8] = '{1'b0, 32'd0,   32'h00000000, 1'b0, 1'b0, 32'd0,   32'h00000000};

    // Reset, then idle.
    step();
    step();
    chk_all_zero("in_reset");
    reset = 1'b0;
    step();
    chk_all_zero("after_reset");
    for (int i = 0; i < 10; i++) begin
      step();
      chk1($sformatf("idle c%0d reg_enable", i), reg_enable, 1'b0);
    end

    // CPU store vectors.
    for (int v = 0; v < 9; v++) begin
      cpu_req   = vec[v].req;
      cpu_index = vec[v].idx;
      cpu_value = vec[v].val;
      step();
      chk1 ($sformatf("cpu v%0d reg_enable", v), reg_enable, vec[v].e_en);
      chk1 ($sformatf("cpu v%0d cpu_ack", v), cpu_ack, vec[v].e_ack);
      chk32($sformatf("cpu v%0d reg_index", v), reg_index, vec[v].e_idx);
      chk32($sformatf("cpu v%0d reg_value", v), reg_value, vec[v].e_val);
      chk1 ($sformatf("cpu v%0d busy", v), busy, 1'b0);
    end
    cpu_req = 1'b0;

    // Plain tick burst.
    burst("b1", 11'h155, -1);
    step();
    chk1("b1 end reg_enable", reg_enable, 1'b0);
    chk1("b1 end busy", busy, 1'b0);
    chk1("b1 end tick_overrun", tick_overrun, 1'b0);

    // Tick and CPU request together: burst first, CPU granted as HEAD exits.
    cpu_req   = 1'b1;
    cpu_index = 32'd104;
    cpu_value = 32'hCAFEF00D;
    burst("b2", 11'h2AA, -1);
    step();
    chk1 ("b2 cpu reg_enable", reg_enable, 1'b1);
    chk1 ("b2 cpu cpu_ack", cpu_ack, 1'b1);
    chk32("b2 cpu reg_index", reg_index, 32'd104);
    chk32("b2 cpu reg_value", reg_value, 32'hCAFEF00D);
    chk1 ("b2 cpu busy", busy, 1'b0);
    cpu_req = 1'b0;
    step();
    chk1("b2 after reg_enable", reg_enable, 1'b0);
    chk1("b2 after cpu_ack", cpu_ack, 1'b0);
    chk1("b2 after tick_overrun", tick_overrun, 1'b0);

    // Second tick during the burst is dropped and sets the sticky overrun.
    burst("b3", 11'h0F0, 5);
    for (int i = 0; i < 6; i++) begin
      step();
      chk1($sformatf("b3 post c%0d reg_enable", i), reg_enable, 1'b0);
      chk1($sformatf("b3 post c%0d busy", i), busy, 1'b0);
      chk1($sformatf("b3 post c%0d tick_overrun", i), tick_overrun, 1'b1);
    end

    // Reset at burst cycle 7 aborts immediately and clears the overrun.
    tick     = 1'b1;
    new_head = 11'h0AB;
    for (int i = 0; i < 7; i++) begin
      step();
      tick = 1'b0;
      chk32($sformatf("b4 c%0d reg_index", i), reg_index, 32'(SB + NS - 1 - i));
    end
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    step();
    chk_all_zero("held_reset");
    reset = 1'b0;
    burst("b5", 11'h7E1, -1);
    step();
    chk1("b5 end reg_enable", reg_enable, 1'b0);
    chk1("b5 end busy", busy, 1'b0);
    chk1("b5 end tick_overrun", tick_overrun, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
